// File: rtl/fl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fl_pkg
// Description : Shared sizes and types for the checkpointed free list, also
//               reused by the RAT and ROB.
// Revision    : 1.0 - initial release
// ============================================================================
package fl_pkg;

  // Default configuration of the free list
  localparam int FL_PR_W     = 6;
  localparam int FL_NUM_PR   = 64;
  localparam int FL_NUM_AR   = 32;
  localparam int FL_POP_W    = 2;
  localparam int FL_PUSH_W   = 2;
  localparam int FL_NUM_CKPT = 4;

  // Derived queue geometry; the pointer carries one extra wrap bit
  localparam int DEPTH = FL_NUM_PR - FL_NUM_AR;
  localparam int IDX_W = $clog2(DEPTH);
  localparam int PTR_W = IDX_W + 1;
  localparam int CNT_W = PTR_W;

  typedef logic [FL_PR_W-1:0] tag_t;
  typedef logic [PTR_W-1:0]   ptr_t;
  typedef logic [CNT_W-1:0]   cnt_t;

  // True when v is a non-zero power of two (queue depth must be one)
  function automatic logic is_pow2(input int v);
    return (v > 0) && ((v & (v - 1)) == 0);
  endfunction

endpackage
`default_nettype wire

// File: rtl/fl_ckpt_file.sv
`default_nettype none
// ============================================================================
// Module      : fl_ckpt_file
// Description : Branch checkpoint store for free-list head pointers.
//               One synchronous write port, one combinational read port.
// Revision    : 1.0 - initial release
// ============================================================================
module fl_ckpt_file
  import fl_pkg::*;
#(
  parameter  int SLOTS = FL_NUM_CKPT,
  parameter  int WIDTH = PTR_W,
  localparam int ID_W  = (SLOTS > 1) ? $clog2(SLOTS) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we_i,
  input  logic [ID_W-1:0]  waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [ID_W-1:0]  raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] slot_q [SLOTS];

  // Snapshot storage: all slots clear to head = 0 on reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SLOTS; i++) begin
        slot_q[i] <= '0;
      end
    end else if (we_i) begin
      slot_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = slot_q[raddr_i];

endmodule
`default_nettype wire

// File: rtl/freelist_ckpt.sv
`default_nettype none
// ============================================================================
// Module      : freelist_ckpt
// Description : Circular free list of physical-register tags with N-wide pop
//               (rename), M-wide push (commit release) and head checkpoints
//               for single-cycle mispredict recovery.
// Revision    : 1.0 - initial release
// ============================================================================
module freelist_ckpt
  import fl_pkg::*;
#(
  parameter  int PR_W     = FL_PR_W,
  parameter  int NUM_PR   = FL_NUM_PR,
  parameter  int NUM_AR   = FL_NUM_AR,
  parameter  int POP_W    = FL_POP_W,
  parameter  int PUSH_W   = FL_PUSH_W,
  parameter  int NUM_CKPT = FL_NUM_CKPT,
  localparam int QDEPTH   = NUM_PR - NUM_AR,
  localparam int QIDX_W   = $clog2(QDEPTH),
  localparam int QPTR_W   = QIDX_W + 1,
  localparam int POPC_W   = $clog2(POP_W + 1),
  localparam int PUSHC_W  = $clog2(PUSH_W + 1),
  localparam int CKID_W   = (NUM_CKPT > 1) ? $clog2(NUM_CKPT) : 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [POPC_W-1:0]      pop_cnt_i,
  output logic [POP_W*PR_W-1:0]  pop_data_o,
  input  logic [PUSHC_W-1:0]     push_cnt_i,
  input  logic [PUSH_W*PR_W-1:0] push_data_i,
  input  logic                   ckpt_save_i,
  input  logic [CKID_W-1:0]      ckpt_id_i,
  input  logic                   ckpt_restore_i,
  input  logic [CKID_W-1:0]      restore_id_i,
  output logic [QPTR_W-1:0]      free_cnt_o,
  output logic                   no_free_pr_o,
  output logic                   one_free_pr_o,
  output logic                   err_o
);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [PR_W-1:0]   queue_q [QDEPTH];
  logic [QPTR_W-1:0] head_q, head_d;
  logic [QPTR_W-1:0] tail_q, tail_d;
  logic              err_q,  err_d;

  // --------------------------------------------------------------------------
  // Next-state signals
  // --------------------------------------------------------------------------
  logic [QPTR_W-1:0] free_cnt;
  logic [QPTR_W-1:0] pop_ext;
  logic [QPTR_W-1:0] pop_amt;
  logic [QPTR_W-1:0] push_ext;
  logic [QPTR_W:0]   occ_after;
  logic              pop_over;
  logic              pop_err;
  logic              push_ok;
  logic              push_err;
  logic [QPTR_W-1:0] ckpt_rdata;
  logic [QIDX_W-1:0] wr_idx [PUSH_W];
  logic              wr_en  [PUSH_W];

  assign free_cnt = tail_q - head_q;
  assign pop_ext  = QPTR_W'(pop_cnt_i);
  assign push_ext = QPTR_W'(push_cnt_i);

  // Pop legality, head update and restore priority over pop
  always_comb begin
    pop_over = (pop_ext > free_cnt) || (pop_cnt_i > POPC_W'(POP_W));
    pop_err  = 1'b0;
    pop_amt  = '0;
    if (!ckpt_restore_i) begin
      if (pop_over) begin
        pop_err = 1'b1;
      end else begin
        pop_amt = pop_ext;
      end
    end
    head_d = ckpt_restore_i ? ckpt_rdata : (head_q + pop_amt);
  end

  // Push legality is judged against the head that will exist after this edge,
  // so a restore that re-exposes tags can make a push overflow.
  always_comb begin
    occ_after = {1'b0, tail_q - head_d} + (QPTR_W + 1)'(push_cnt_i);
    push_ok   = 1'b0;
    push_err  = 1'b0;
    if (push_cnt_i != '0) begin
      if ((occ_after <= (QPTR_W + 1)'(QDEPTH)) &&
          (push_cnt_i <= PUSHC_W'(PUSH_W))) begin
        push_ok = 1'b1;
      end else begin
        push_err = 1'b1;
      end
    end
    tail_d = push_ok ? (tail_q + push_ext) : tail_q;
    err_d  = err_q | pop_err | push_err;
  end

  // Per-lane write enables and queue slots for the push
  always_comb begin
    for (int k = 0; k < PUSH_W; k++) begin
      wr_idx[k] = tail_q[QIDX_W-1:0] + QIDX_W'(k);
      wr_en[k]  = push_ok && (k < int'(push_cnt_i));
    end
  end

  // Head, tail and sticky error registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q <= '0;
      tail_q <= QPTR_W'(QDEPTH);
      err_q  <= 1'b0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      err_q  <= err_d;
    end
  end

  // Tag storage: preloaded with the unmapped PRs, written at the tail on push
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < QDEPTH; i++) begin
        queue_q[i] <= PR_W'(NUM_AR + i);
      end
    end else begin
      for (int k = 0; k < PUSH_W; k++) begin
        if (wr_en[k]) begin
          queue_q[wr_idx[k]] <= push_data_i[k*PR_W +: PR_W];
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Checkpoints: the snapshot is the post-pop (or restored) head
  // --------------------------------------------------------------------------
  fl_ckpt_file #(
    .SLOTS (NUM_CKPT),
    .WIDTH (QPTR_W)
  ) u_ckpt (
    .clk     (clk),
    .rst_n   (rst_n),
    .we_i    (ckpt_save_i),
    .waddr_i (ckpt_id_i),
    .wdata_i (head_d),
    .raddr_i (restore_id_i),
    .rdata_o (ckpt_rdata)
  );

  // --------------------------------------------------------------------------
  // Zero-latency read of the next POP_W tags at the head
  // --------------------------------------------------------------------------
  for (genvar k = 0; k < POP_W; k++) begin : g_pop
    logic [QIDX_W-1:0] rd_idx;
    assign rd_idx = head_q[QIDX_W-1:0] + QIDX_W'(k);
    assign pop_data_o[k*PR_W +: PR_W] = queue_q[rd_idx];
  end

  assign free_cnt_o    = free_cnt;
  assign no_free_pr_o  = (free_cnt == '0);
  assign one_free_pr_o = (free_cnt == QPTR_W'(1));
  assign err_o         = err_q;

endmodule
`default_nettype wire
